// File: rtl/record_pkg.sv
// Shared helpers for the multi-channel sample recorder.
// Derived widths and the channel packing index.
package record_pkg;

   localparam int DEF_NUM_CH = 1;
   localparam int DEF_WORD_W = 32;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_CNT_W  = 16;

   function automatic int bitCntW(input int wordW);
      return $clog2(wordW);
   endfunction

   function automatic int ptrW(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int fillW(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int packIdx(input int ch, input int wordW);
      return ch * wordW;
   endfunction

endpackage

// File: rtl/record_fifo.sv
// Synchronous FIFO with push-while-full allowed when a pop
// frees a slot in the same cycle.
module record_fifo
   import record_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         pushData,
   output logic                     pushOk,
   output logic [WIDTH-1:0]         headData,
   output logic                     full,
   output logic                     empty,
   output logic [fillW(DEPTH)-1:0]  level
);

   localparam int PW = ptrW(DEPTH);
   localparam int LW = fillW(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [LW-1:0]    cnt;
   logic             doPop;

   assign empty    = (cnt == '0);
   assign full     = (cnt == LW'(DEPTH));
   assign doPop    = pop & ~empty;
   assign pushOk   = push & (~full | doPop);
   assign headData = mem[rdPtr];
   assign level    = cnt;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + PW'(1);
         if (doPop)  rdPtr <= rdPtr + PW'(1);
         if (pushOk && !doPop)
            cnt <= cnt + LW'(1);
         else if (doPop && !pushOk)
            cnt <= cnt - LW'(1);
      end
   end

   // Storage needs no reset; the head is ignored while empty.
   always_ff @(posedge clk) begin
      if (resetN && pushOk) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/sample_record_fifo.sv
// Multi-channel serial sample recorder: shifts one bit per channel
// per sample edge and queues each completed word set.
module sample_record_fifo
   import record_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int WORD_W     = DEF_WORD_W,
   parameter int FIFO_DEPTH = DEF_DEPTH,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                           clk,
   input  logic                           resetN,
   input  logic                           enable,
   input  logic                           samplePulse,
   input  logic [NUM_CH-1:0]              dIn,
   input  logic                           msbFirst,
   input  logic                           flush,
   input  logic                           clrStatus,
   output logic [NUM_CH*WORD_W-1:0]       outData,
   output logic                           outValid,
   input  logic                           outReady,
   output logic [fillW(FIFO_DEPTH)-1:0]   fillLevel,
   output logic [bitCntW(WORD_W)-1:0]     bitCount,
   output logic                           overflow,
   output logic [CNT_W-1:0]               dropCount
);

   localparam int BC_W = bitCntW(WORD_W);
   localparam int DW   = NUM_CH * WORD_W;

   logic              spD;
   logic              shiftEn;
   logic              wordDone;
   logic              pushOk;
   logic              drop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [WORD_W-1:0] sr     [NUM_CH];
   logic [WORD_W-1:0] srNext [NUM_CH];
   logic [DW-1:0]     pushWord;

   assign shiftEn  = enable & samplePulse & ~spD;
   assign wordDone = shiftEn & ~flush &
                     (bitCount == BC_W'(WORD_W - 1));
   assign drop     = wordDone & ~pushOk;
   assign outValid = ~fifoEmpty;

   always_comb begin
      srNext   = '{default: '0};
      pushWord = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         srNext[c] = msbFirst ? {sr[c][WORD_W-2:0], dIn[c]}
                              : {dIn[c], sr[c][WORD_W-1:1]};
         pushWord[packIdx(c, WORD_W) +: WORD_W] = srNext[c];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         spD      <= 1'b0;
         bitCount <= '0;
         for (int c = 0; c < NUM_CH; c++) sr[c] <= '0;
      end else begin
         spD <= samplePulse;
         if (flush) begin
            bitCount <= '0;
            for (int c = 0; c < NUM_CH; c++) sr[c] <= '0;
         end else if (shiftEn) begin
            bitCount <= wordDone ? '0 : bitCount + BC_W'(1);
            for (int c = 0; c < NUM_CH; c++) sr[c] <= srNext[c];
         end
      end
   end

   // A drop in the same cycle as clrStatus restarts the count at one.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         overflow  <= 1'b0;
         dropCount <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clrStatus)
            dropCount <= CNT_W'(1);
         else if (!(&dropCount))
            dropCount <= dropCount + CNT_W'(1);
      end else if (clrStatus) begin
         overflow  <= 1'b0;
         dropCount <= '0;
      end
   end

   record_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk      (clk),
      .resetN   (resetN),
      .push     (wordDone),
      .pop      (outReady),
      .pushData (pushWord),
      .pushOk   (pushOk),
      .headData (outData),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .level    (fillLevel)
   );

endmodule

// File: tb/tb_sample_record_fifo.sv
// Randomized bench for sample_record_fifo with a queue-based
// reference model of the sample/word/FIFO behaviour.
module tb_sample_record_fifo;

   localparam int NC = 2;
   localparam int WW = 8;
   localparam int FD = 4;
   localparam int CW = 16;

   logic          clk;
   logic          resetN;
   logic          enable;
   logic          samplePulse;
   logic [NC-1:0] dIn;
   logic          msbFirst;
   logic          flush;
   logic          clrStatus;
   logic [15:0]   outData;
   logic          outValid;
   logic          outReady;
   logic [2:0]    fillLevel;
   logic [2:0]    bitCount;
   logic          overflow;
   logic [CW-1:0] dropCount;

   int nChecks = 0;
   int nFail   = 0;

   sample_record_fifo #(
      .NUM_CH (NC), .WORD_W (WW),
      .FIFO_DEPTH (FD), .CNT_W (CW)
   ) dut (
      .clk (clk), .resetN (resetN), .enable (enable),
      .samplePulse (samplePulse), .dIn (dIn),
      .msbFirst (msbFirst), .flush (flush),
      .clrStatus (clrStatus), .outData (outData),
      .outValid (outValid), .outReady (outReady),
      .fillLevel (fillLevel), .bitCount (bitCount),
      .overflow (overflow), .dropCount (dropCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: list of pending samples, queue of words
   bit          mSp;
   logic [1:0]  mSamp[$];
   logic [15:0] mFifo[$];
   bit          mOvf;
   int          mDrops;
   int          dutPops;
   bit          mPop, mShift, mAcc, mDrop;
   logic [15:0] mWord;
   int          pos;

   always @(posedge clk) begin
      if (resetN && outValid && outReady) dutPops++;
      mPop   = resetN && mFifo.size() > 0 && outReady;
      mShift = enable && samplePulse && !mSp;
      mSp    = resetN ? samplePulse : 1'b0;
      mAcc   = 0;
      mDrop  = 0;
      if (!resetN) begin
         mSamp.delete();
         mFifo.delete();
         mOvf   = 0;
         mDrops = 0;
      end else begin
         if (flush) mSamp.delete();
         else if (mShift) begin
            mSamp.push_back(dIn);
            if (mSamp.size() == WW) begin
               mWord = '0;
               for (int i = 0; i < WW; i++) begin
                  pos = msbFirst ? WW - 1 - i : i;
                  mWord[pos]      = mSamp[i][0];
                  mWord[WW + pos] = mSamp[i][1];
               end
               mSamp.delete();
               if (mFifo.size() < FD || mPop) mAcc = 1;
               else mDrop = 1;
            end
         end
         if (mPop) void'(mFifo.pop_front());
         if (mAcc) mFifo.push_back(mWord);
         if (mDrop) begin
            mOvf = 1;
            if (clrStatus) mDrops = 1;
            else if (mDrops < 65535) mDrops++;
         end else if (clrStatus) begin
            mOvf   = 0;
            mDrops = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [1:0] d);
      samplePulse = 1'b1;
      dIn = d;
      tick();
      samplePulse = 1'b0;
      tick();
   endtask

   task automatic doReset();
      resetN = 1'b0;
      enable = 1'b1;
      samplePulse = 1'b0;
      dIn = '0;
      msbFirst = 1'b0;
      flush = 1'b0;
      clrStatus = 1'b0;
      outReady = 1'b1;
      tick();
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      samplePulse = 1'b1;
      pulse(2'b11);
      doReset();
      nChecks++;
      if (outValid !== 1'b0 || fillLevel !== 3'd0) begin
         nFail++;
         $display("FAIL reset_fifo: valid=%b fill=%0d want 0/0",
                  outValid, fillLevel);
      end
      nChecks++;
      if (bitCount !== 3'd0 || overflow !== 1'b0 ||
          dropCount !== 16'd0) begin
         nFail++;
         $display("FAIL reset_status: bc=%0d ovf=%b dc=%0d want 0",
                  bitCount, overflow, dropCount);
      end
   endtask

   task automatic test_order(input bit msb, input logic [15:0] want);
      logic [7:0] pat;
      pat = 8'b0000_1101;
      doReset();
      msbFirst = msb;
      for (int i = 0; i < 7; i++) pulse({1'b1, pat[i]});
      samplePulse = 1'b1;
      dIn = {1'b1, pat[7]};
      tick();
      nChecks++;
      if (outValid !== 1'b1 || outData !== want) begin
         nFail++;
         $display("FAIL order_msb%0d: valid=%b data=%h want 1/%h",
                  msb, outValid, outData, want);
      end
      nChecks++;
      if (mFifo.size() != 1 || mFifo[0] !== want) begin
         nFail++;
         $display("FAIL order_model_msb%0d: model disagrees, want %h",
                  msb, want);
      end
      samplePulse = 1'b0;
      tick();
      nChecks++;
      if (outValid !== 1'b0) begin
         nFail++;
         $display("FAIL order_onecycle: valid=%b want 0", outValid);
      end
   endtask

   task automatic test_edge(input bit en);
      int p0;
      doReset();
      enable = en;
      p0 = dutPops;
      samplePulse = 1'b1;
      dIn = 2'b01;
      repeat (10) tick();
      nChecks++;
      if (bitCount !== (en ? 3'd1 : 3'd0)) begin
         nFail++;
         $display("FAIL edge_hold_en%0d: bc=%0d want %0d",
                  en, bitCount, en ? 1 : 0);
      end
      samplePulse = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) pulse(2'($urandom));
      nChecks++;
      if (bitCount !== 3'd0 || dutPops - p0 != (en ? 1 : 0)) begin
         nFail++;
         $display("FAIL edge_words_en%0d: bc=%0d words=%0d want 0/%0d",
                  en, bitCount, dutPops - p0, en ? 1 : 0);
      end
   endtask

   task automatic test_overflow();
      int p0;
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 40; i++) pulse(2'($urandom));
      nChecks++;
      if (fillLevel !== 3'd4 || overflow !== 1'b1 ||
          dropCount !== 16'd1) begin
         nFail++;
         $display("FAIL ovf_state: fill=%0d ovf=%b dc=%0d want 4/1/1",
                  fillLevel, overflow, dropCount);
      end
      p0 = dutPops;
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nChecks++;
         if (outValid !== 1'b1 || outData !== mFifo[0]) begin
            nFail++;
            $display("FAIL ovf_drain%0d: valid=%b data=%h want 1/%h",
                     i, outValid, outData, mFifo[0]);
         end
         tick();
      end
      nChecks++;
      if (outValid !== 1'b0 || dutPops - p0 != 4) begin
         nFail++;
         $display("FAIL ovf_fifth: valid=%b pops=%0d want 0/4",
                  outValid, dutPops - p0);
      end
      clrStatus = 1'b1;
      tick();
      clrStatus = 1'b0;
      nChecks++;
      if (overflow !== 1'b0 || dropCount !== 16'd0) begin
         nFail++;
         $display("FAIL ovf_clear: ovf=%b dc=%0d want 0/0",
                  overflow, dropCount);
      end
   endtask

   task automatic test_flush_reset();
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) pulse(2'b00);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      nChecks++;
      if (bitCount !== 3'd0) begin
         nFail++;
         $display("FAIL flush_bc: bc=%0d want 0", bitCount);
      end
      for (int i = 0; i < 8; i++) pulse({1'($urandom), 1'b1});
      nChecks++;
      if (outValid !== 1'b1 || outData[7:0] !== 8'hFF ||
          fillLevel !== 3'd1) begin
         nFail++;
         $display("FAIL flush_word: valid=%b ch0=%h fill=%0d want 1/ff/1",
                  outValid, outData[7:0], fillLevel);
      end
      outReady = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) pulse(2'b11);
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      nChecks++;
      if (bitCount !== 3'd0 || outValid !== 1'b0 ||
          fillLevel !== 3'd0) begin
         nFail++;
         $display("FAIL midword_reset: bc=%0d valid=%b fill=%0d want 0",
                  bitCount, outValid, fillLevel);
      end
   endtask

   task automatic test_full_pushpop();
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 39; i++) pulse(2'($urandom));
      samplePulse = 1'b1;
      dIn = 2'($urandom);
      outReady = 1'b1;
      tick();
      nChecks++;
      if (fillLevel !== 3'd4 || overflow !== 1'b0 ||
          dropCount !== 16'd0) begin
         nFail++;
         $display("FAIL full_pushpop: fill=%0d ovf=%b dc=%0d want 4/0/0",
                  fillLevel, overflow, dropCount);
      end
      samplePulse = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nChecks++;
         if (outData !== mFifo[0]) begin
            nFail++;
            $display("FAIL full_drain%0d: data=%h want %h",
                     i, outData, mFifo[0]);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [27:0] got, exp;
      doReset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         samplePulse = 1'($urandom);
         dIn = 2'($urandom);
         enable = ($urandom_range(0, 9) != 0);
         outReady = (cyc % 500 < 250) ? ($urandom_range(0, 7) == 0)
                                      : ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 59) == 0);
         clrStatus = ($urandom_range(0, 79) == 0);
         if (flush) begin
            enable = 1'b0;
            msbFirst = 1'($urandom);
         end
         tick();
         got = {outValid, fillLevel, bitCount, overflow,
                dropCount, 4'h0};
         exp = {mFifo.size() > 0, 3'(mFifo.size()),
                3'(mSamp.size()), mOvf, 16'(mDrops), 4'h0};
         nChecks++;
         if (got !== exp) begin
            nFail++;
            $display("FAIL rand_state@%0d: got %h want %h",
                     cyc, got, exp);
         end
         if (mFifo.size() > 0) begin
            nChecks++;
            if (outData !== mFifo[0]) begin
               nFail++;
               $display("FAIL rand_data@%0d: got %h want %h",
                        cyc, outData, mFifo[0]);
            end
         end
      end
      flush = 1'b0;
      clrStatus = 1'b0;
   endtask

   initial begin
      dutPops = 0;
      resetN = 1'b0;
      enable = 1'b0;
      samplePulse = 1'b0;
      dIn = '0;
      msbFirst = 1'b0;
      flush = 1'b0;
      clrStatus = 1'b0;
      outReady = 1'b0;
      tick();
      test_reset();
      test_order(1'b0, 16'hFF0D);
      test_order(1'b1, 16'hFFB0);
      test_edge(1'b1);
      test_edge(1'b0);
      test_overflow();
      test_flush_reset();
      test_full_pushpop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/sample_record_fifo.md
Name: sample_record_fifo

Overview:
Multi-channel successor to the single-channel 32-bit sample recorder. On each rising edge of samplePulse, it shifts one bit per channel into per-channel shift registers. Every WORD_W samples, it packs the channel words and pushes them into an output FIFO with a valid/ready handshake. The block adds selectable bit order, partial-word flush, overflow detection and drop counting, and sits between the channel sampling front-end and the AXI/readout logic.

Parameters:
NUM_CH, 1, number of serial data channels sampled in parallel
WORD_W, 32, samples per word (bits per channel word), 2..64
FIFO_DEPTH, 4, output FIFO entries, power of 2, >=2
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  clock
resetN  in  1  synchronous active-low reset
enable  in  1  gates sample-edge acceptance
samplePulse  in  1  sample strobe, level; rising edge detected internally
dIn  in  NUM_CH  serial data, bit c = channel c
msbFirst  in  1  bit-order mode, quasi-static (change only while enable=0)
flush  in  1  synchronous discard of the partial word
clrStatus  in  1  clears overflow and dropCount
outData  out  NUM_CH*WORD_W  FIFO head; channel c at [c*WORD_W +: WORD_W]
outValid  out  1  FIFO not empty
outReady  in  1  consumer accept; pop when outValid&outReady
fillLevel  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
bitCount  out  $clog2(WORD_W)  samples taken in current word
overflow  out  1  sticky: a completed word was dropped
dropCount  out  CNT_W  saturating count of dropped words

Behaviour:
- Reset (resetN=0 at a clk edge): shift registers=0, bitCount=0, sp_d=0, FIFO empty (outValid=0, fillLevel=0), overflow=0, dropCount=0. outData is don't-care while outValid=0. Reset mid-word or mid-handshake discards everything.
- Edge detection: sp_d <= samplePulse every cycle. shiftEn = enable & samplePulse & ~sp_d. A level held high yields exactly one shift. sp_d updates even while enable=0, so enabling during a held-high pulse does not produce a shift.
- Shift when shiftEn:
  - msbFirst=0: sr <= {dIn[c], sr[WORD_W-1:1]}. The first sample ends in bit 0.
  - msbFirst=1: sr <= {sr[WORD_W-2:0], dIn[c]}. The first sample ends in the MSB.
- bitCount increments on each shift. On the shift where bitCount==WORD_W-1, bitCount wraps to 0 and the word (including that bit, from the next-state shift value) is offered to the FIFO in the same cycle.
- Push acceptance: accepted if fillLevel<FIFO_DEPTH, or if a pop occurs in the same cycle. An accepted push and pop in the same cycle leaves fillLevel unchanged.
- Dropped word: if the push is not accepted, the word is lost, overflow <= 1, and dropCount increments, saturating at all-ones.
- flush=1: shift registers and bitCount clear to 0, and any shift that cycle is ignored. FIFO contents are untouched. flush has priority over shiftEn.
- clrStatus=1: clears overflow and dropCount. If a drop occurs in the same cycle, the drop wins: overflow=1, dropCount=1.
- enable=0: edges are ignored, the partial word is held, and the FIFO still drains.
- FIFO latency:
  - A pushed word appears at outData/outValid the cycle after the push edge.
  - outData is stable while outValid=1 and outReady=0.
  - The next entry appears the cycle after a pop.
- All arithmetic is unsigned with no wrap on dropCount. The FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Package record_pkg: function for the pack index (c*WORD_W) and localparams for the derived widths (count, pointer, fill).
- One sub-module, record_fifo: a synchronous FIFO parametrised by width and depth, with push/pop/full/empty/level and registered head output.
- Edge detect, shift registers, counters and status live in the top module.

Test Plan:
All scenarios use NUM_CH=2, WORD_W=8, FIFO_DEPTH=4, CNT_W=16.
1. msbFirst=0, ch0 bits 1,0,1,1,0,0,0,0, ch1 all 1, eight pulses, outReady=1 -> one word: outData[7:0]=8'h0D, [15:8]=8'hFF. outValid high for 1 cycle, starting one cycle after the 8th shift.
2. Same bits with msbFirst=1 -> outData[7:0]=8'hB0, [15:8]=8'hFF.
3. samplePulse held high 10 cycles, then low, then 7 single-cycle pulses -> exactly 8 shifts, bitCount returns to 0, one word. Repeat with enable=0 -> no shifts, bitCount=0.
4. outReady=0, 40 pulses (5 words) -> fillLevel=4, overflow=1, dropCount=1. Then outReady=1 -> words 1..4 delivered in order, and word 5 is never seen. clrStatus -> overflow=0, dropCount=0.
5. 3 pulses, flush, then 8 pulses with ch0 all 1 -> single word ch0=8'hFF (pre-flush bits absent). 3 pulses, then resetN=0 one cycle -> bitCount=0, outValid=0, FIFO empty.
6. FIFO full with outReady=1 and a word completing in the same cycle -> push accepted, fillLevel stays 4, overflow stays 0.
